// File: rtl/sampler_rle.sv
// Logic-analyzer input sampler: clock divider, group masking,
// change-only run-length suppression and a valid/ready output stage.
module sampler_rle #(
  parameter int CHLS  = 32,
  parameter int GRP_W = 8,
  parameter int DIV_W = 24,
  parameter int RPT_W = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DIV_W-1:0]      fdiv_i,
  input  logic                  set_div_i,
  input  logic                  run_i,
  input  logic                  chg_mode_i,
  input  logic [CHLS/GRP_W-1:0] grp_en_i,
  input  logic [CHLS-1:0]       data_i,
  output logic [CHLS-1:0]       smpls_o,
  output logic [RPT_W-1:0]      rpt_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  ovf_o
);

  localparam int NGRP = CHLS / GRP_W;
  localparam logic [RPT_W-1:0] RPT_MAX = '1;

  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] cnt;
  logic [CHLS-1:0]  ref_smp;
  logic [CHLS-1:0]  m;
  logic [RPT_W-1:0] sup;
  logic [RPT_W-1:0] rpt;
  logic             armed;
  logic             run_q;
  logic             rise;
  logic             armed_eff;
  logic             tick;
  logic             emit;
  logic             accept;
  logic             drop;

  // Force disabled channel groups to zero
  always_comb begin
    m = '0;
    for (int g = 0; g < NGRP; g++) begin
      if (grp_en_i[g]) begin
        m[g*GRP_W +: GRP_W] = data_i[g*GRP_W +: GRP_W];
      end
    end
  end

  // Tick generation and emit/suppress decision
  always_comb begin
    rise      = run_i & ~run_q;
    armed_eff = armed & ~rise;
    tick      = run_i & ~set_div_i & (cnt >= r_div);
    emit      = 1'b0;
    rpt       = '0;
    if (tick) begin
      if (!chg_mode_i || !armed_eff) begin
        emit = 1'b1;
      end else if (m != ref_smp) begin
        emit = 1'b1;
        rpt  = sup;
      end else if (sup == RPT_MAX) begin
        emit = 1'b1;
        rpt  = RPT_MAX;
      end
    end
    accept = emit & (~valid_o | ready_i);
    drop   = emit & valid_o & ~ready_i;
  end

  // Divider: period is r_div+1 clocks, a new factor restarts the count
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_div <= '0;
      cnt   <= '0;
    end else if (set_div_i) begin
      r_div <= fdiv_i;
      cnt   <= '0;
    end else if (!run_i || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Run-length state: last emitted sample, suppressed ticks, armed flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      run_q   <= 1'b0;
      armed   <= 1'b0;
      sup     <= '0;
      ref_smp <= '0;
    end else begin
      run_q <= run_i;
      if (!run_i) begin
        sup   <= '0;
        armed <= 1'b0;
      end else if (emit) begin
        sup   <= '0;
        armed <= 1'b1;
      end else if (tick) begin
        sup <= sup + 1'b1;
      end
      if (accept) begin
        ref_smp <= m;
      end
    end
  end

  // Output register with handshake and sticky overflow
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      smpls_o <= '0;
      rpt_o   <= '0;
      valid_o <= 1'b0;
      ovf_o   <= 1'b0;
    end else begin
      if (accept) begin
        smpls_o <= m;
        rpt_o   <= rpt;
        valid_o <= 1'b1;
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
      if (drop) begin
        ovf_o <= 1'b1;
      end else if (rise) begin
        ovf_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sampler_rle.sv
// Directed bench for sampler_rle: divider, masking, change-only
// compression with saturation, backpressure overflow and reset.
module tb_sampler_rle;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] fdiv;
  logic        set_div;
  logic        run;
  logic        chg;
  logic [3:0]  grp_en;
  logic [31:0] data;
  logic [31:0] smpls;
  logic [3:0]  rpt;
  logic        valid;
  logic        ready;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  sampler_rle #(
    .CHLS (32),
    .GRP_W(8),
    .DIV_W(24),
    .RPT_W(4)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .fdiv_i    (fdiv),
    .set_div_i (set_div),
    .run_i     (run),
    .chg_mode_i(chg),
    .grp_en_i  (grp_en),
    .data_i    (data),
    .smpls_o   (smpls),
    .rpt_o     (rpt),
    .valid_o   (valid),
    .ready_i   (ready),
    .ovf_o     (ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int seen;
    rst     = 1'b1;
    fdiv    = '0;
    set_div = 1'b0;
    run     = 1'b0;
    chg     = 1'b0;
    grp_en  = 4'hF;
    data    = '0;
    ready   = 1'b1;
    step();
    step();
    chk("rst_smpls", 64'(smpls), 64'(0));
    chk("rst_rpt",   64'(rpt),   64'(0));
    chk("rst_valid", 64'(valid), 64'(0));
    chk("rst_ovf",   64'(ovf),   64'(0));
    rst = 1'b0;

    // continuous, r_div=0: one sample per clock
    run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data = 32'h10 + 32'(i);
      step();
      chk("cont_valid", 64'(valid), 64'(1));
      chk("cont_smpls", 64'(smpls), 64'(32'h10 + 32'(i)));
      chk("cont_rpt",   64'(rpt),   64'(0));
    end
    run = 1'b0;
    step();
    chk("stop_valid", 64'(valid), 64'(0));

    // divide by 4
    set_div = 1'b1;
    fdiv    = 24'd3;
    step();
    set_div = 1'b0;
    run     = 1'b1;
    data    = 32'hA5;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("div4_valid", 64'(valid), 64'(k == 4 || k == 8));
    end
    for (int k = 0; k < 3; k++) begin
      step();
      chk("div4_gap", 64'(valid), 64'(0));
    end
    // reload where cnt==3 would have ticked
    set_div = 1'b1;
    fdiv    = 24'd1;
    step();
    chk("set_notick", 64'(valid), 64'(0));
    set_div = 1'b0;
    step();
    chk("div2_a", 64'(valid), 64'(0));
    step();
    chk("div2_b", 64'(valid), 64'(1));
    step();
    chk("div2_c", 64'(valid), 64'(0));
    step();
    chk("div2_d", 64'(valid), 64'(1));

    // group masking
    set_div = 1'b1;
    fdiv    = 24'd0;
    step();
    chk("set0_valid", 64'(valid), 64'(0));
    set_div = 1'b0;
    grp_en  = 4'b0101;
    data    = 32'hFFFF_FFFF;
    step();
    chk("mask_valid", 64'(valid), 64'(1));
    chk("mask_smpls", 64'(smpls), 64'(32'h00FF_00FF));
    run    = 1'b0;
    grp_en = 4'hF;
    step();

    // change-only: A,A,A,A,B
    chg  = 1'b1;
    run  = 1'b1;
    data = 32'h1234;
    step();
    chk("rle_first_v", 64'(valid), 64'(1));
    chk("rle_first_d", 64'(smpls), 64'(32'h1234));
    chk("rle_first_r", 64'(rpt),   64'(0));
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rle_supp", 64'(valid), 64'(0));
    end
    data = 32'hBEEF;
    step();
    chk("rle_b_v", 64'(valid), 64'(1));
    chk("rle_b_d", 64'(smpls), 64'(32'hBEEF));
    chk("rle_b_r", 64'(rpt),   64'(3));

    // saturation at 15 suppressed ticks
    seen = 0;
    repeat (15) begin
      step();
      if (valid) seen++;
    end
    chk("sat_quiet", 64'(seen), 64'(0));
    step();
    chk("sat_v", 64'(valid), 64'(1));
    chk("sat_r", 64'(rpt),   64'(15));
    chk("sat_d", 64'(smpls), 64'(32'hBEEF));
    run = 1'b0;
    step();

    // backpressure and overflow
    chg   = 1'b0;
    ready = 1'b0;
    data  = 32'h55;
    run   = 1'b1;
    step();
    chk("bp_v1",   64'(valid), 64'(1));
    chk("bp_d1",   64'(smpls), 64'(32'h55));
    chk("bp_ovf1", 64'(ovf),   64'(0));
    data = 32'h66;
    step();
    chk("bp_d2",   64'(smpls), 64'(32'h55));
    chk("bp_ovf2", 64'(ovf),   64'(1));
    data = 32'h77;
    step();
    chk("bp_d3",   64'(smpls), 64'(32'h55));
    ready = 1'b1;
    step();
    chk("rdy_d",   64'(smpls), 64'(32'h77));
    chk("rdy_ovf", 64'(ovf),   64'(1));
    run = 1'b0;
    step();
    chk("fall_ovf", 64'(ovf),   64'(1));
    chk("fall_v",   64'(valid), 64'(0));
    run = 1'b1;
    step();
    chk("rise_ovf", 64'(ovf),   64'(0));
    chk("rise_v",   64'(valid), 64'(1));
    ready = 1'b0;
    step();
    chk("ovf_again", 64'(ovf), 64'(1));

    // reset mid-run
    rst = 1'b1;
    step();
    chk("mrst_smpls", 64'(smpls), 64'(0));
    chk("mrst_rpt",   64'(rpt),   64'(0));
    chk("mrst_valid", 64'(valid), 64'(0));
    chk("mrst_ovf",   64'(ovf),   64'(0));
    rst = 1'b0;
    run = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
